// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and fetch-state encoding for the operand-fetch stage.
package rf_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int XZR_IDX = 2**DEF_ADDR_W - 1;
  typedef enum logic [1:0] {OF_IDLE, OF_LIVE, OF_HOLD} of_state_e;
endpackage

// File: rtl/rf_operand_fetch_if.sv
// rf_operand_fetch_if: decode-side request and execute-side operand handshakes.
interface rf_operand_fetch_if import rf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TAG_W = 32
);
  logic req_valid, req_ready;
  logic [ADDR_W-1:0] req_rs1, req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic out_valid, out_ready;
  logic [DATA_W-1:0] out_op1, out_op2;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output req_valid, req_rs1, req_rs2, req_tag, out_ready,
    input req_ready, out_valid, out_op1, out_op2, out_tag
  );
  modport slave (
    input req_valid, req_rs1, req_rs2, req_tag, out_ready,
    output req_ready, out_valid, out_op1, out_op2, out_tag
  );
endinterface

// File: rtl/of_snoop_slot.sv
// of_snoop_slot: one operand's source index, bypass flag and bypass/hold data with writeback snoop.
// OF_WB_BYPASS_EN adds the accept-edge bypass; the hold snoop is always present.
module of_snoop_slot import rf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              capture,
  input  logic              hold,
  input  logic [ADDR_W-1:0] rs_in,
  input  logic [DATA_W-1:0] rd,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op
);
  localparam logic [ADDR_W-1:0] ZR = '1;
  logic [ADDR_W-1:0] rs;
  logic flag, hit_cur;
  logic [DATA_W-1:0] data;
  assign hit_cur = wb_we && wb_addr == rs && rs != ZR;
  assign op = hold ? data : rs == ZR ? '0 : flag ? data : rd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rs <= '0;
    else if (load) rs <= rs_in;
`ifdef OF_WB_BYPASS_EN
  logic hit_new;
  assign hit_new = wb_we && wb_addr == rs_in && rs_in != ZR;
  always_ff @(posedge clk or negedge rst)
    if (!rst) flag <= 1'b0;
    else if (load) flag <= hit_new;
  // data doubles as bypass value while live and as held operand while stalled
  always_ff @(posedge clk or negedge rst)
    if (!rst) data <= '0;
    else if (load) data <= wb_data;
    else if (capture || hold) data <= hit_cur ? wb_data : op;
`else
  assign flag = 1'b0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) data <= '0;
    else if (capture || hold) data <= hit_cur ? wb_data : op;
`endif
endmodule

// File: rtl/rf_operand_fetch.sv
// rf_operand_fetch: regfile read client presenting stall-safe operands to execute.
// OF_WB_BYPASS_EN: same-edge writeback bypass; undefined: one-cycle interlock on writeback conflicts.
module rf_operand_fetch import rf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TAG_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  rf_operand_fetch_if.slave bus,
  output logic [ADDR_W-1:0] ReadRegister1,
  output logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);
  localparam logic [ADDR_W-1:0] ZR = '1;
  of_state_e state, state_nx;
  logic accept, wb_clash, capture, hold;
  logic [DATA_W-1:0] op1, op2;
  logic [TAG_W-1:0] tag;
`ifdef OF_WB_BYPASS_EN
  assign wb_clash = 1'b0;
`else
  assign wb_clash = wb_we && wb_addr != ZR && (wb_addr == bus.req_rs1 || wb_addr == bus.req_rs2);
`endif
  always_comb begin
    bus.req_ready = (state == OF_IDLE || bus.out_ready) && !wb_clash;
    accept = bus.req_valid && bus.req_ready;
    state_nx = (state == OF_IDLE || bus.out_ready) ? (accept ? OF_LIVE : OF_IDLE) : OF_HOLD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= OF_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) tag <= '0;
    else if (accept) tag <= bus.req_tag;
  assign capture = state == OF_LIVE && !bus.out_ready;
  assign hold = state == OF_HOLD;
  assign ReadRegister1 = bus.req_rs1;
  assign ReadRegister2 = bus.req_rs2;
  assign bus.out_valid = state != OF_IDLE;
  assign bus.out_op1 = bus.out_valid ? op1 : '0;
  assign bus.out_op2 = bus.out_valid ? op2 : '0;
  assign bus.out_tag = tag;
  of_snoop_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) slot1 (
    .clk(clk), .rst(rst), .load(accept), .capture(capture), .hold(hold), .rs_in(bus.req_rs1),
    .rd(ReadData1), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .op(op1)
  );
  of_snoop_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) slot2 (
    .clk(clk), .rst(rst), .load(accept), .capture(capture), .hold(hold), .rs_in(bus.req_rs2),
    .rd(ReadData2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .op(op2)
  );
endmodule

// File: doc/rf_operand_fetch.md
Name: rf_operand_fetch

Overview:
- Read-side client of the 64-bit, 32-entry register file (synchronous read, one-cycle latency, index 31 = XZR).
- Sits between decode and execute. Accepts one source-pair request per cycle and drives the register-file read addresses.
- Snoops the writeback port to fix read-during-write staleness. Presents operands to execute with a valid/ready handshake, holding and updating them across stalls.

Parameters:
- DATA_W, 64, register/operand width.
- ADDR_W, 5, register index width; zero-register index = 2**ADDR_W-1.
- TAG_W, 32, opaque sideband (instruction/dest info) carried with the request.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  decode offers a request.
- req_ready  output  1  request accepted at posedge when req_valid && req_ready.
- req_rs1, req_rs2  input  ADDR_W  source indices.
- req_tag  input  TAG_W  sideband.
- ReadRegister1, ReadRegister2  output  ADDR_W  to regfile; combinationally = req_rs1/req_rs2.
- ReadData1, ReadData2  input  DATA_W  from regfile, valid one cycle after the address edge.
- wb_we  input  1  writeback snoop, same signals that drive regfile RegWrite.
- wb_addr  input  ADDR_W  writeback snoop, WriteRegister.
- wb_data  input  DATA_W  writeback snoop, WriteData.
- out_valid  output  1  operands valid.
- out_ready  input  1  execute consumes at posedge when out_valid && out_ready.
- out_op1, out_op2  output  DATA_W  operands.
- out_tag  output  TAG_W  sideband.

Behaviour:
- Reset: state=IDLE, out_valid=0, out_op1/out_op2/out_tag=0, all bypass/hold registers and flags cleared. Reset mid-operation drops any in-flight request with no output.
- req_ready = (state==IDLE) || out_ready. Without OF_WB_BYPASS_EN it is further gated, see Optional Feature.
- States:
  - IDLE: accept -> LIVE; otherwise stay IDLE.
  - LIVE (operands from this cycle's ReadData): out_ready && accept -> LIVE; out_ready && !accept -> IDLE; !out_ready -> HOLD.
  - HOLD (operands in hold registers): same transitions as LIVE, except !out_ready -> stay HOLD.
- Latency: request accepted at edge t -> out_valid in cycle t+1. Throughput is one per cycle when out_ready is held high.
- Accept-edge bypass, per operand: if wb_we && wb_addr==rsN && rsN!=31 at the accept edge, latch byp_flagN=1 and byp_dataN=wb_data. This covers the regfile returning the old value on a same-edge write.
- LIVE output: opN = (rsN==31) ? 0 : byp_flagN ? byp_dataN : ReadDataN.
- LIVE -> HOLD edge: capture the current opN into holdN. If wb_we && wb_addr==rsN && rsN!=31 on that edge, capture wb_data instead (youngest write wins).
- In HOLD: on every edge with wb_we && wb_addr==held rsN && rsN!=31, update holdN with wb_data. Both operands update if rs1==rs2.
- Zero register: rsN==31 always yields 0 and ignores any snooped write to 31.
- out_tag: registered at the accept edge, stable until consumed.
- While out_valid && !out_ready, out_op1/out_op2 may change only through the snoop update; out_tag never changes.
- ReadRegister1/2 follow req_rs1/req_rs2 even when not accepting. Harmless, since the regfile read has no side effect.

Optional Feature:
- Macro OF_WB_BYPASS_EN.
- Defined: the accept-edge and hold snoop bypass operate as described above.
- Undefined:
  - No bypass registers.
  - req_ready is additionally forced 0 when wb_we && wb_addr!=31 && (wb_addr==req_rs1 || wb_addr==req_rs2). This costs a one-cycle interlock; the request is accepted the following cycle and reads the committed value.
  - The HOLD snoop update is still performed, so held operands are never stale.

Decomposition:
- Package rf_pkg: XZR_IDX constant (31), DATA_W/ADDR_W defaults, and an enum of fetch states {OF_IDLE, OF_LIVE, OF_HOLD}.
- One natural sub-module, of_snoop_slot: a per-operand register holding rs, flag and data, plus the match/update logic. Instantiate it twice.

Test Plan:
- Reset release, regfile preloaded X3=0x11, X4=0x22; request rs1=3, rs2=4, tag=0xA5, out_ready=1 -> next cycle out_valid=1, op1=0x11, op2=0x22, out_tag=0xA5.
- Same-edge conflict: accept rs1=5 while wb_we=1, wb_addr=5, wb_data=0x99 -> op1=0x99, not the old X5. With the macro undefined: req_ready=0 that cycle, then accepted and op1=0x99 one cycle later.
- Stall: out_ready=0 for 3 cycles holding rs2=7; write X7=0x1234 in cycle 2 -> out_op2 becomes 0x1234 the cycle after the write, out_tag unchanged; release -> consumed once.
- XZR: rs1=31, rs2=31 with wb_we=1, wb_addr=31, wb_data=0xFF -> op1=op2=0.
- Back-to-back: 8 requests on consecutive cycles, out_ready=1 -> 8 outputs in order on consecutive cycles, req_ready never drops (macro defined).
- Async reset asserted mid-HOLD -> out_valid=0, outputs 0 immediately without a clock edge; no stale output after release.
